// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD engine: control state encoding and default width.
package gcd_pkg;

  localparam int GCD_WL = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } gcd_state_e;

endpackage

// File: rtl/gcd_if.sv
// Operand/result valid-ready bundle. The master drives operands and consumes results.
interface gcd_if
  import gcd_pkg::*;
#(
  parameter int WL = GCD_WL
);

  logic          ops_val;
  logic          ops_rdy;
  logic [WL-1:0] ops_a;
  logic [WL-1:0] ops_b;
  logic          res_val;
  logic          res_rdy;
  logic [WL-1:0] res_data;

  modport master (
    output ops_val, ops_a, ops_b, res_rdy,
    input  ops_rdy, res_val, res_data
  );

  modport slave (
    input  ops_val, ops_a, ops_b, res_rdy,
    output ops_rdy, res_val, res_data
  );

endinterface

// File: rtl/gcd_datapath.sv
// A/B operand registers with load, swap and subtract paths; reports A<B and B==0 to control.
module gcd_datapath #(
  parameter int WL = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic          swap_i,
  input  logic          sub_i,
  input  logic [WL-1:0] a_i,
  input  logic [WL-1:0] b_i,
  output logic          a_lt_b_o,
  output logic          b_zero_o,
  output logic [WL-1:0] result_o
);

  logic [WL-1:0] a_q;
  logic [WL-1:0] b_q;
  logic [WL-1:0] a_d;
  logic [WL-1:0] b_d;
  logic          a_en_s;
  logic          b_en_s;

  // Next-value muxes; subtraction is only enabled when A >= B, so it never wraps.
  always_comb begin
    a_d = a_q - b_q;
    b_d = b_q;
    if (load_i) begin
      a_d = a_i;
      b_d = b_i;
    end else if (swap_i) begin
      a_d = b_q;
      b_d = a_q;
    end else begin
      a_d = a_q - b_q;
      b_d = b_q;
    end
  end

  assign a_en_s = load_i | swap_i | sub_i;
  assign b_en_s = load_i | swap_i;

  gcd_reg #(.W(WL)) u_reg_a (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (a_en_s),
    .d_i   (a_d),
    .q_o   (a_q)
  );

  gcd_reg #(.W(WL)) u_reg_b (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (b_en_s),
    .d_i   (b_d),
    .q_o   (b_q)
  );

  assign a_lt_b_o = (a_q < b_q);
  assign b_zero_o = (b_q == '0);
  assign result_o = a_q;

endmodule

// File: rtl/gcd_reg.sv
// Shared enable register with asynchronous active-high clear.
module gcd_reg #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;

  // Storage element: clear on reset, load on enable.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q <= '0;
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/gcd_unit.sv
// Iterative subtract-and-swap Euclid GCD: control FSM around gcd_datapath.
module gcd_unit
  import gcd_pkg::*;
#(
  parameter int WL = GCD_WL
) (
  input  logic clk,
  input  logic rst,
  gcd_if.slave bus
);

  gcd_state_e state_q;
  gcd_state_e state_d;
  logic       load_s;
  logic       swap_s;
  logic       sub_s;
  logic       a_lt_b_s;
  logic       b_zero_s;
  logic       ops_rdy_s;
  logic       res_val_s;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.ops_val) begin
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        if (!a_lt_b_s && b_zero_s) begin
          state_d = DONE;
        end else begin
          state_d = CALC;
        end
      end
      DONE: begin
        if (bus.res_rdy) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode; handshake outputs depend on state only.
  always_comb begin
    load_s    = 1'b0;
    swap_s    = 1'b0;
    sub_s     = 1'b0;
    ops_rdy_s = 1'b0;
    res_val_s = 1'b0;
    case (state_q)
      IDLE: begin
        ops_rdy_s = 1'b1;
        load_s    = bus.ops_val;
      end
      CALC: begin
        swap_s = a_lt_b_s;
        sub_s  = !a_lt_b_s && !b_zero_s;
      end
      DONE: begin
        res_val_s = 1'b1;
      end
      default: begin
        ops_rdy_s = 1'b0;
        res_val_s = 1'b0;
      end
    endcase
  end

  gcd_datapath #(.WL(WL)) u_dp (
    .clk_i    (clk),
    .rst_i    (rst),
    .load_i   (load_s),
    .swap_i   (swap_s),
    .sub_i    (sub_s),
    .a_i      (bus.ops_a),
    .b_i      (bus.ops_b),
    .a_lt_b_o (a_lt_b_s),
    .b_zero_o (b_zero_s),
    .result_o (bus.res_data)
  );

  assign bus.ops_rdy = ops_rdy_s;
  assign bus.res_val = res_val_s;

endmodule
